input_conditioner: RTL

//  Multi-channel conditioner for raw board inputs (KEY pushbuttons, SW switches) ahead of the

---
 rtl/input_conditioner_if.sv | 27 ++
 rtl/input_conditioner.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/input_conditioner_if.sv
// Bus bundle for input_conditioner: raw board inputs in, conditioned levels and strobes out.
// The master side drives raw_in and observes the conditioned outputs; the slave side is the conditioner.
interface input_conditioner_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] raw_in;
  logic [N_CH-1:0] level_out;
  logic [N_CH-1:0] press_pulse;
  logic [N_CH-1:0] release_pulse;
  logic [N_CH-1:0] repeat_pulse;

  modport master (
    output raw_in,
    input  level_out,
    input  press_pulse,
    input  release_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  raw_in,
    output level_out,
    output press_pulse,
    output release_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/input_conditioner.sv
// Multi-channel input conditioner: per channel a 2-flop synchroniser, polarity normalisation,
// counter debounce, one-cycle press/release strobes and optional held-key auto-repeat.
// Optional feature: define INPUT_CONDITIONER_AUTOREPEAT_EN to build the auto-repeat FSMs;
// without it repeat_pulse is tied low and REPEAT_DELAY/REPEAT_RATE/REP_W are unused.
module input_conditioner #(
  parameter int N_CH         = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int CNT_W        = 20,
  parameter int REPEAT_DELAY = 12500000,
  parameter int REPEAT_RATE  = 2500000,
  parameter int REP_W        = 24
) (
  input logic              CLOCK_50,
  input logic              reset,
  input_conditioner_if.slave bus
);

  // Inversion mask that maps every channel onto "1 = pressed/active".
  localparam logic [N_CH-1:0] POL_MASK = (ACTIVE_LOW != 0) ? {N_CH{1'b1}} : {N_CH{1'b0}};
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [N_CH-1:0] s1_q;
  logic [N_CH-1:0] s2_q;
  logic [N_CH-1:0] level_vec;
  logic [N_CH-1:0] press_vec;
  logic [N_CH-1:0] release_vec;
  logic [N_CH-1:0] repeat_vec;

  // Two-flop synchroniser on the normalised inputs; reset value is "inactive".
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= bus.raw_in ^ POL_MASK;
      s2_q <= s1_q;
    end
  end

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_RATE} rpt_state_t;
  localparam logic [REP_W-1:0] DLY_LAST  = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST = REP_W'(REPEAT_RATE - 1);
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi = gi + 1) begin : g_ch
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             level_q, level_d;
      logic             press_q, press_d;
      logic             release_q, release_d;

      // Debounce: count consecutive cycles where the synchronised input disagrees with the level.
      always_comb begin
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (s2_q[gi] == level_q) begin
          cnt_d = '0;
        end else if (cnt_q == DEB_LAST) begin
          cnt_d     = '0;
          level_d   = s2_q[gi];
          press_d   = s2_q[gi];
          release_d = ~s2_q[gi];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Debounce state and edge strobes; strobes change on the same edge as the level.
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          cnt_q     <= '0;
          level_q   <= 1'b0;
          press_q   <= 1'b0;
          release_q <= 1'b0;
        end else begin
          cnt_q     <= cnt_d;
          level_q   <= level_d;
          press_q   <= press_d;
          release_q <= release_d;
        end
      end

      assign level_vec[gi]   = level_q;
      assign press_vec[gi]   = press_q;
      assign release_vec[gi] = release_q;

`ifdef INPUT_CONDITIONER_AUTOREPEAT_EN
      rpt_state_t       state_q, state_d;
      logic [REP_W-1:0] rcnt_q, rcnt_d;
      logic             rep_q, rep_d;

      // Auto-repeat next state: press arms the initial delay, release cancels, otherwise count.
      always_comb begin
        state_d = state_q;
        rcnt_d  = rcnt_q;
        rep_d   = 1'b0;
        if (press_d) begin
          state_d = RPT_DELAY;
          rcnt_d  = '0;
        end else if (release_d) begin
          state_d = RPT_IDLE;
          rcnt_d  = '0;
        end else begin
          case (state_q)
            RPT_DELAY: begin
              if (rcnt_q == DLY_LAST) begin
                rep_d   = 1'b1;
                rcnt_d  = '0;
                state_d = RPT_RATE;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            RPT_RATE: begin
              if (rcnt_q == RATE_LAST) begin
                rep_d  = 1'b1;
                rcnt_d = '0;
              end else begin
                rcnt_d = rcnt_q + 1'b1;
              end
            end
            default: rcnt_d = '0;
          endcase
        end
      end

      // Auto-repeat state register; reset discards any in-flight repeat count.
      always_ff @(posedge CLOCK_50) begin
        if (reset) begin
          state_q <= RPT_IDLE;
          rcnt_q  <= '0;
          rep_q   <= 1'b0;
        end else begin
          state_q <= state_d;
          rcnt_q  <= rcnt_d;
          rep_q   <= rep_d;
        end
      end

      assign repeat_vec[gi] = rep_q;
`else
      assign repeat_vec[gi] = 1'b0;
`endif
    end
  endgenerate

  assign bus.level_out     = level_vec;
  assign bus.press_pulse   = press_vec;
  assign bus.release_pulse = release_vec;
  assign bus.repeat_pulse  = repeat_vec;

endmodule
